multi_blink_led: RTL and testbench

MULTI_BLINK_LED -- requirements
Module: multi_blink_led

---
 rtl/multi_blink_led.sv | 109 ++++++++++
 tb/tb_multi_blink_led.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multi_blink_led.sv
`default_nettype none
// ============================================================================
// Module   : multi_blink_led
// Purpose  : Independent per-channel LED driver with OFF / ON / BLINK / BURST
//            modes, programmed through a single-cycle write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module multi_blink_led #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 26,
    parameter int BURST_W  = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [3:0]          wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [CNT_W-1:0]    wr_half,
    input  logic [BURST_W-1:0]  wr_count,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [3:0] CH_IDX = 4'(i);

        logic [1:0]         ch_mode;
        logic [CNT_W-1:0]   ch_half;
        logic [CNT_W-1:0]   ch_counter;
        logic [BURST_W-1:0] ch_remaining;
        logic               ch_led;
        logic               ch_done;
        logic               ch_wr;
        logic               ch_running;

        assign ch_wr      = wr_en && (wr_ch == CH_IDX);
        assign ch_running = (ch_mode == MODE_BLINK) || (ch_mode == MODE_BURST);

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                ch_mode      <= MODE_OFF;
                ch_half      <= '0;
                ch_counter   <= '0;
                ch_remaining <= '0;
                ch_led       <= 1'b0;
                ch_done      <= 1'b0;
            end else begin
                ch_done <= 1'b0;
                // A write always wins over a same-cycle terminal event.
                if (ch_wr) begin
                    ch_half      <= wr_half;
                    ch_counter   <= '0;
                    ch_remaining <= wr_count;
                    case (wr_mode)
                        MODE_ON: begin
                            ch_mode <= MODE_ON;
                            ch_led  <= 1'b1;
                        end
                        MODE_BLINK: begin
                            ch_mode <= MODE_BLINK;
                            ch_led  <= 1'b1;
                        end
                        MODE_BURST: begin
                            if (wr_count == '0) begin
                                ch_mode <= MODE_OFF;
                                ch_led  <= 1'b0;
                            end else begin
                                ch_mode <= MODE_BURST;
                                ch_led  <= 1'b1;
                            end
                        end
                        default: begin
                            ch_mode <= MODE_OFF;
                            ch_led  <= 1'b0;
                        end
                    endcase
                end else if (ch_running) begin
                    if (ch_counter == ch_half) begin
                        ch_counter <= '0;
                        ch_led     <= ~ch_led;
                        // Falling edge of a burst pulse consumes one count.
                        if ((ch_mode == MODE_BURST) && ch_led) begin
                            ch_remaining <= ch_remaining - BURST_W'(1);
                            if (ch_remaining == BURST_W'(1)) begin
                                ch_mode <= MODE_OFF;
                                ch_led  <= 1'b0;
                                ch_done <= 1'b1;
                            end
                        end
                    end else begin
                        ch_counter <= ch_counter + CNT_W'(1);
                    end
                end
            end
        end

        assign led[i]  = ch_led;
        assign busy[i] = (ch_mode == MODE_BURST);
        assign done[i] = ch_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_blink_led.sv
`default_nettype none
// Scoreboard bench for multi_blink_led: directed scenarios followed by random
// writes, checked against a cycles-since-write arithmetic model.
module tb_multi_blink_led;

    localparam int CH      = 4;
    localparam int CNT_W   = 26;
    localparam int BURST_W = 8;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               wr_en = 1'b0;
    logic [3:0]         wr_ch = '0;
    logic [1:0]         wr_mode = '0;
    logic [CNT_W-1:0]   wr_half = '0;
    logic [BURST_W-1:0] wr_count = '0;
    logic [CH-1:0]      led;
    logic [CH-1:0]      busy;
    logic [CH-1:0]      done;

    multi_blink_led #(.CHANNELS(CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_mode(wr_mode), .wr_half(wr_half), .wr_count(wr_count),
        .led(led), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Model: mode, half, count and the number of edges since the last write.
    int m_mode [CH];
    int m_half [CH];
    int m_cnt  [CH];
    int m_k    [CH];

    logic [3*CH-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void model_edge(input bit rn, input bit en, input int ch,
                                       input int md, input int hf, input int ct);
        logic [CH-1:0] e_led, e_busy, e_done;
        int term;
        e_led = '0; e_busy = '0; e_done = '0;
        for (int c = 0; c < CH; c++) begin
            if (!rn) begin
                m_mode[c] = 0;
                m_k[c]    = 0;
            end else if (en && ch == c) begin
                m_mode[c] = md;
                m_half[c] = hf;
                m_cnt[c]  = ct;
                m_k[c]    = 0;
                if (md == 3 && ct == 0) m_mode[c] = 0;
            end else begin
                m_k[c]++;
            end
            case (m_mode[c])
                1: e_led[c] = 1'b1;
                2: e_led[c] = ((m_k[c] / (m_half[c] + 1)) % 2) == 0;
                3: begin
                    // Terminal edge is the start of phase 2*count-1 (the last fall).
                    term = (2 * m_cnt[c] - 1) * (m_half[c] + 1);
                    if (m_k[c] == term) begin
                        e_done[c] = 1'b1;
                        m_mode[c] = 0;
                    end else begin
                        e_led[c]  = ((m_k[c] / (m_half[c] + 1)) % 2) == 0;
                        e_busy[c] = 1'b1;
                    end
                end
                default: e_led[c] = 1'b0;
            endcase
        end
        exp_q.push_back({e_led, e_busy, e_done});
    endfunction

    task automatic step(input bit rn, input bit en, input int ch,
                        input int md, input int hf, input int ct);
        reset_n  = rn;
        wr_en    = en;
        wr_ch    = 4'(ch);
        wr_mode  = 2'(md);
        wr_half  = CNT_W'(hf);
        wr_count = BURST_W'(ct);
        @(posedge clock);
        #1;
        model_edge(rn, en, ch, md, hf, ct);
        reset_n = 1'b1;
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle; check away from the edge.
    initial begin
        logic [3*CH-1:0] e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (led !== e[3*CH-1:2*CH]) begin
                    n_fail++;
                    $display("FAIL led t=%0t got=%b want=%b", $time, led, e[3*CH-1:2*CH]);
                end
                n_cmp++;
                if (busy !== e[2*CH-1:CH]) begin
                    n_fail++;
                    $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e[2*CH-1:CH]);
                end
                n_cmp++;
                if (done !== e[CH-1:0]) begin
                    n_fail++;
                    $display("FAIL done t=%0t got=%b want=%b", $time, done, e[CH-1:0]);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0; m_half[c] = 0; m_cnt[c] = 0; m_k[c] = 0;
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // ch0 BLINK half=3
        step(1, 1, 0, 2, 3, 0);
        idle(20);
        // ch1 BURST half=1 count=3
        step(1, 1, 1, 3, 1, 3);
        idle(14);
        // ch2 fast blink, ch3 ON, out-of-range ch5
        step(1, 1, 2, 2, 0, 0);
        step(1, 1, 3, 1, 0, 0);
        step(1, 1, 5, 1, 0, 0);
        idle(6);
        // ch1 BURST count=1 half=2, rewritten on its terminal edge
        step(1, 1, 1, 3, 2, 1);
        idle(2);
        step(1, 1, 1, 2, 1, 0);
        idle(5);
        // ch1 BURST count=0 behaves as OFF
        step(1, 1, 1, 3, 4, 0);
        idle(3);
        // reset mid-burst on ch1
        step(1, 1, 1, 3, 1, 5);
        idle(4);
        step(0, 0, 0, 0, 0, 0);
        idle(3);
        // write coincident with reset is dropped
        step(0, 1, 0, 1, 0, 0);
        idle(3);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) != 0), ($urandom_range(3) == 0),
                 int'($urandom_range(5)), int'($urandom_range(3)),
                 int'($urandom_range(5)), int'($urandom_range(4)));
        end
        @(negedge clock);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
